// File: rtl/aoi22_bist_pkg.sv
// Shared types, constants and reference functions for the AOI22 BIST sequencer.
package aoi22_bist_pkg;

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;

  localparam int unsigned MISR_W    = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic [VEC_W-1:0] vec_to_gray(logic [VEC_W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // g = {A1, A2, B1, B2}
  function automatic logic expected_zn(logic [VEC_W-1:0] g);
    return ~((g[3] & g[2]) | (g[1] & g[0]));
  endfunction

  function automatic logic [15:0] misr_step(logic [15:0] sig, logic din);
    logic fb;
    fb = sig[15] ^ din;
    return {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/aoi22_bist_misr.sv
// Single-input signature register compacting the sampled ZN stream.
module aoi22_bist_misr
  import aoi22_bist_pkg::*;
(
  input  logic              CLK,
  input  logic              RN,
  input  logic              seed,
  input  logic              shift,
  input  logic              din,
  output logic [MISR_W-1:0] signature
);

  logic [MISR_W-1:0] sig_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sig_q <= MISR_SEED;
    end else if (seed) begin
      sig_q <= MISR_SEED;
    end else if (shift) begin
      sig_q <= misr_step(sig_q, din);
    end
  end

  assign signature = sig_q;

endmodule

// File: rtl/aoi22_bist_ctrl.sv
// Gray-code BIST sequencer for one AOI22 cell: drives all 16 input vectors, checks ZN.
// Optional MISR signature output is enabled by defining AOI22_BIST_MISR_EN.
module aoi22_bist_ctrl
  import aoi22_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RN,
  inout  wire                  VDD,
  inout  wire                  VSS,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ZN,
  output logic                 A1,
  output logic                 A2,
  output logic                 B1,
  output logic                 B2,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [3:0]           first_fail_vec,
`ifdef AOI22_BIST_MISR_EN
  output logic [15:0]          signature,
`endif
  output logic                 first_fail_valid
);

  localparam int unsigned SetW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;

  if (SETTLE_CYCLES < 1) begin : gen_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (PASSES < 1) begin : gen_bad_passes
    $error("PASSES must be at least 1");
  end

  // Supplies are only present for netlist connectivity.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  state_e                 state_q, state_d;
  logic [SetW-1:0]        settle_q, settle_d;
  logic [PassW-1:0]       pass_idx_q, pass_idx_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic [VEC_W-1:0]       drv_q, drv_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]       ffv_q, ffv_d;
  logic                   ffvalid_q, ffvalid_d;
  logic                   last_vec;

  assign last_vec = (vec_q == VEC_W'(NUM_VEC - 1)) && (pass_idx_q == PassW'(PASSES - 1));

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    pass_idx_d = pass_idx_q;
    vec_d      = vec_q;
    drv_d      = drv_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    ffv_d      = ffv_q;
    ffvalid_d  = ffvalid_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSettle;
          settle_d   = '0;
          pass_idx_d = '0;
          vec_d      = '0;
          drv_d      = vec_to_gray('0);
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          err_d      = '0;
          ffv_d      = '0;
          ffvalid_d  = 1'b0;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          drv_d   = '0;
          pass_d  = 1'b0;
        end else if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      StSample: begin
        if (abort) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          drv_d   = '0;
          pass_d  = 1'b0;
        end else begin
          if (ZN != expected_zn(drv_q)) begin
            if (err_q != {ERR_CNT_W{1'b1}}) err_d = err_q + ERR_CNT_W'(1);
            if (!ffvalid_q) begin
              ffv_d     = drv_q;
              ffvalid_d = 1'b1;
            end
          end
          if (last_vec) begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            drv_d   = '0;
            pass_d  = (err_d == '0);
          end else begin
            state_d  = StSettle;
            settle_d = '0;
            vec_d    = vec_q + VEC_W'(1);
            drv_d    = vec_to_gray(vec_d);
            if (vec_q == VEC_W'(NUM_VEC - 1)) pass_idx_d = pass_idx_q + PassW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      pass_idx_q <= '0;
      vec_q      <= '0;
      drv_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ffv_q      <= '0;
      ffvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      pass_idx_q <= pass_idx_d;
      vec_q      <= vec_d;
      drv_q      <= drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      ffv_q      <= ffv_d;
      ffvalid_q  <= ffvalid_d;
    end
  end

  assign {A1, A2, B1, B2}  = drv_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_cnt          = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

`ifdef AOI22_BIST_MISR_EN
  logic misr_seed, misr_shift;
  assign misr_seed  = (state_q == StIdle) && start;
  assign misr_shift = (state_q == StSample) && !abort;

  aoi22_bist_misr u_misr (
    .CLK       (CLK),
    .RN        (RN),
    .seed      (misr_seed),
    .shift     (misr_shift),
    .din       (ZN),
    .signature (signature)
  );
`endif

endmodule

// File: tb/tb_aoi22_bist_ctrl.sv
// Scoreboard bench for aoi22_bist_ctrl: random cell defects, aborts, stray starts and resets.
module tb_aoi22_bist_ctrl;

  localparam int unsigned S0 = 2, P0 = 1, W0 = 8;
  localparam int unsigned S1 = 2, P1 = 3, W1 = 4;

  typedef struct {
    int unsigned k;
    int unsigned done_edge;
    bit          pass;
    int unsigned err;
    logic [3:0]  ffv;
    bit          ffvalid;
    logic [15:0] sig;
  } exp_t;

  logic CLK = 1'b0, RN = 1'b0;
  wire  vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic        start0 = 0, abort0 = 0, start1 = 0, abort1 = 0;
  logic        a1_0, a2_0, b1_0, b2_0, busy0, done0, pass0, ffvalid0;
  logic        a1_1, a2_1, b1_1, b2_1, busy1, done1, pass1, ffvalid1;
  logic [W0-1:0] err0;
  logic [W1-1:0] err1;
  logic [3:0]  ffv0, ffv1;
  logic [15:0] sig0, sig1;
  logic [15:0] mask0 = 0, mask1 = 0;
  logic        zn0, zn1;

  int unsigned checks = 0, passes = 0, seq_err0 = 0;
  exp_t q0[$], q1[$];

  function automatic logic good_zn(logic [3:0] g);
    return !((g[3] && g[2]) || (g[1] && g[0]));
  endfunction

  // Defective cell: ZN inverted for every vector whose mask bit is set.
  assign zn0 = good_zn({a1_0, a2_0, b1_0, b2_0}) ^ mask0[{a1_0, a2_0, b1_0, b2_0}];
  assign zn1 = good_zn({a1_1, a2_1, b1_1, b2_1}) ^ mask1[{a1_1, a2_1, b1_1, b2_1}];

  aoi22_bist_ctrl #(.SETTLE_CYCLES(S0), .PASSES(P0), .ERR_CNT_W(W0)) dut0 (
    .CLK(CLK), .RN(RN), .VDD(vdd), .VSS(vss), .start(start0), .abort(abort0), .ZN(zn0),
    .A1(a1_0), .A2(a2_0), .B1(b1_0), .B2(b2_0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_fail_vec(ffv0),
`ifdef AOI22_BIST_MISR_EN
    .signature(sig0),
`endif
    .first_fail_valid(ffvalid0)
  );

  aoi22_bist_ctrl #(.SETTLE_CYCLES(S1), .PASSES(P1), .ERR_CNT_W(W1)) dut1 (
    .CLK(CLK), .RN(RN), .VDD(vdd), .VSS(vss), .start(start1), .abort(abort1), .ZN(zn1),
    .A1(a1_1), .A2(a2_1), .B1(b1_1), .B2(b2_1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail_vec(ffv1),
`ifdef AOI22_BIST_MISR_EN
    .signature(sig1),
`endif
    .first_fail_valid(ffvalid1)
  );

`ifndef AOI22_BIST_MISR_EN
  initial begin
    sig0 = 16'hFFFF;
    sig1 = 16'hFFFF;
  end
`endif

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: walk the Gray sequence sample by sample, count mismatches, stop early on abort.
  function automatic exp_t model(int unsigned k, int unsigned np, int unsigned st,
                                 int unsigned w, logic [15:0] mask, int unsigned abort_at);
    exp_t e;
    int unsigned nsamp, errs, v;
    logic [3:0] g;
    logic zn;
    e.k = k;
    nsamp = 16 * np;
    e.done_edge = k + nsamp * (st + 1);
    if (abort_at != 0) begin
      nsamp = (abort_at - 1) / (st + 1);
      e.done_edge = k + abort_at;
    end
    errs = 0; e.ffv = 0; e.ffvalid = 0; e.sig = 16'hFFFF;
    for (int n = 0; n < int'(nsamp); n++) begin
      v = n % 16;
      g = 4'(v ^ (v >> 1));
      zn = good_zn(g) ^ mask[g];
      if (zn != good_zn(g)) begin
        errs++;
        if (!e.ffvalid) begin e.ffv = g; e.ffvalid = 1; end
      end
`ifdef AOI22_BIST_MISR_EN
      e.sig = aoi22_bist_pkg::misr_step(e.sig, zn);
`endif
    end
    e.err = (errs > (1 << w) - 1) ? (1 << w) - 1 : errs;
    e.pass = (abort_at == 0) && (errs == 0);
    return e;
  endfunction

  function automatic logic [15:0] stuck_mask(logic val);
    logic [15:0] m;
    for (int g = 0; g < 16; g++) m[g] = (good_zn(4'(g)) != val);
    return m;
  endfunction

  // Monitor for dut0: expected drive per cycle, and result pop on done.
  always @(negedge CLK) begin
    if (RN) begin
      if (q0.size() > 0 && cyc >= q0[0].k && cyc < q0[0].done_edge) begin
        int unsigned v;
        logic [3:0] g;
        v = ((cyc - q0[0].k) / (S0 + 1)) % 16;
        g = 4'(v ^ (v >> 1));
        if ({a1_0, a2_0, b1_0, b2_0} !== g || busy0 !== 1'b1 || done0 !== 1'b0) seq_err0++;
      end
      if (done0 === 1'b1) begin
        chk("done0_expected", 32'(q0.size() > 0), 32'd1);
        if (q0.size() > 0) begin
          exp_t e;
          e = q0.pop_front();
          chk("done0_edge", cyc, e.done_edge);
          chk("pass0", 32'(pass0), 32'(e.pass));
          chk("err_cnt0", 32'(err0), e.err);
          chk("ffv0", 32'(ffv0), 32'(e.ffv));
          chk("ffvalid0", 32'(ffvalid0), 32'(e.ffvalid));
          chk("busy0_at_done", 32'(busy0), 32'd0);
          chk("drive0_at_done", 32'({a1_0, a2_0, b1_0, b2_0}), 32'd0);
`ifdef AOI22_BIST_MISR_EN
          chk("signature0", 32'(sig0), 32'(e.sig));
`endif
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RN && done1 === 1'b1) begin
      chk("done1_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("done1_edge", cyc, e.done_edge);
        chk("pass1", 32'(pass1), 32'(e.pass));
        chk("err_cnt1", 32'(err1), e.err);
        chk("ffv1", 32'(ffv1), 32'(e.ffv));
        chk("ffvalid1", 32'(ffvalid1), 32'(e.ffvalid));
`ifdef AOI22_BIST_MISR_EN
        chk("signature1", 32'(sig1), 32'(e.sig));
`endif
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_pass", 32'(pass0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_ffv", 32'(ffv0), 0);
    chk("rst_ffvalid", 32'(ffvalid0), 0);
    chk("rst_drive", 32'({a1_0, a2_0, b1_0, b2_0}), 0);
    chk("rst_signature", 32'(sig0), 32'hFFFF);
  endtask

  task automatic run0(logic [15:0] mask, int unsigned abort_at, bit stray, bit with_abort);
    exp_t e;
    int unsigned k, guard;
    @(negedge CLK);
    mask0 = mask; start0 = 1; abort0 = with_abort;
    @(posedge CLK); #1;
    start0 = 0; abort0 = 0; k = cyc;
    e = model(k, P0, S0, W0, mask, abort_at);
    q0.push_back(e);
    guard = 0;
    while (cyc <= e.done_edge && guard < 400) begin
      @(negedge CLK);
      guard++;
      abort0 = (abort_at != 0) && (cyc == k + abort_at - 1);
      start0 = stray && (cyc <= e.done_edge) && ($urandom_range(0, 7) == 0);
    end
    start0 = 0; abort0 = 0;
    chk("run0_completed", q0.size(), 0);
    chk("drive_seq0_errors", seq_err0, 0);
    q0.delete();
    seq_err0 = 0;
  endtask

  task automatic run1(logic [15:0] mask);
    exp_t e;
    int unsigned guard;
    @(negedge CLK);
    mask1 = mask; start1 = 1;
    @(posedge CLK); #1;
    start1 = 0;
    e = model(cyc, P1, S1, W1, mask, 0);
    q1.push_back(e);
    guard = 0;
    while (cyc <= e.done_edge && guard < 400) begin
      @(negedge CLK);
      guard++;
    end
    chk("run1_completed", q1.size(), 0);
    q1.delete();
  endtask

  initial begin
    RN = 0;
    repeat (3) @(negedge CLK);
    check_reset_vals();
    RN = 1;
    @(negedge CLK);

    run0(16'h0000, 0, 0, 0);             // good cell
    run0(stuck_mask(1'b1), 0, 0, 0);     // ZN stuck at 1
    run0(stuck_mask(1'b0), 0, 0, 0);     // ZN stuck at 0
    run0(16'($urandom), 10, 1, 0);       // abort after 10 cycles, stray starts
    // abort ignored while idle
    @(negedge CLK); abort0 = 1;
    @(negedge CLK); abort0 = 0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] m;
      m = 16'($urandom) & 16'($urandom);
      run0(m, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 48) : 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    // asynchronous reset in the middle of a run: no done, outputs at reset values
    @(negedge CLK);
    mask0 = 16'hA5A5; start0 = 1;
    @(posedge CLK); #1;
    start0 = 0;
    repeat ($urandom_range(5, 30)) @(negedge CLK);
    #2 RN = 0;
    #1 check_reset_vals();
    repeat (2) @(negedge CLK);
    RN = 1;
    repeat (6) @(negedge CLK);
    chk("no_done_after_reset", 32'(done0), 0);

    run1(stuck_mask(1'b0));              // 27 mismatches saturate a 4-bit counter
    run1(16'($urandom));

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aoi22_bist_ctrl.md
# aoi22_bist_ctrl

Built-in self-test sequencer for one 9-track 5 V AOI22 cell instance (ZN = !((A1&A2)|(B1&B2))). It drives the cell's four inputs through all 16 combinations in Gray-code order, waits a programmable settle time, samples ZN, compares it against the expected value, and reports pass/fail, an error count and the first failing vector. It sits beside the cell under test on silicon-characterisation and library-qualification test chips, under a host or scan controller that issues start and reads results.

## Interface
- SETTLE_CYCLES, 2, cycles each vector is held before ZN is sampled; must be ≥1, elaboration error if 0.
- PASSES, 1, number of full 16-vector sweeps per run; must be ≥1.
- ERR_CNT_W, 8, width of the error counter.

- CLK  in  1  clock, rising edge.
- RN  in  1  asynchronous, active-low reset.
- VDD, VSS  inout  1  supplies; no functional use.
- start  in  1  run request; sampled in IDLE only.
- abort  in  1  terminates a run in progress.
- ZN  in  1  output of the cell under test.
- A1, A2, B1, B2  out  1  drive the cell under test.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  err_cnt==0 and not aborted; valid from done until the next start.
- err_cnt  out  ERR_CNT_W  mismatch count; saturates at all-ones.
- first_fail_vec  out  4  {A1,A2,B1,B2} of the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured value.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 → SETTLE. Load vector 0. Clear err_cnt, pass, first_fail_*. Set busy=1.
- SETTLE: hold the vector for SETTLE_CYCLES cycles, then → SAMPLE.
- SAMPLE: compare ZN against the expected value at the closing edge.
  - Not the last vector → next vector, SETTLE.
  - Last vector of the last pass → DONE.
- DONE: done=1, busy=0, inputs driven to 0000 → IDLE on the next edge.
- Vector sequence: 4-bit binary index v, wrapping 15→0 between passes. Drive g = v^(v>>1) with g[3]=A1, g[2]=A2, g[1]=B1, g[0]=B2. Exactly one input toggles per step, including the wrap.
- Expected ZN: !((g3&g2)|(g1&g0)).
- Mismatch handling:
  - err_cnt increments, saturating.
  - On the first mismatch of a run, first_fail_vec=g and first_fail_valid=1. Later mismatches do not overwrite it.
- abort=1 in SETTLE or SAMPLE → DONE at the next edge, pass=0, no sample taken that cycle.
- Ignored inputs:
  - abort in IDLE or DONE.
  - start outside IDLE.
- abort and start together in IDLE: start is accepted; abort is ignored.
- Reset values:
  - state IDLE.
  - busy, done, pass, first_fail_valid = 0.
  - err_cnt = 0, first_fail_vec = 0.
  - A1, A2, B1, B2 = 0.
- Reset mid-run: asynchronous return to reset values; no done pulse.

## Timing
- start accepted at edge k: vector 0 appears after edge k.
- Sample edges: k + n·(SETTLE_CYCLES+1) for n = 1…16·PASSES.
- done is high in the cycle after edge k + 16·PASSES·(SETTLE_CYCLES+1). With the defaults, after edge k+48.
- err_cnt and first_fail_* update on the sample edge and are visible the same cycle done rises, at the latest.
- A new start is accepted at the earliest in the cycle after done.
- All outputs are registered.

## Configuration
- AOI22_BIST_MISR_EN defined:
  - Adds output `signature` [15:0]: a 16-bit MISR, polynomial x^16+x^12+x^5+1.
  - Seeded to 16'hFFFF on start acceptance. Shifts in sampled ZN on each sample edge. Held after done.
  - Reset value 16'hFFFF.
- AOI22_BIST_MISR_EN undefined: the port and the logic are absent. All other behaviour is identical.

## Structure
- Package aoi22_bist_pkg holds:
  - state enum;
  - VEC_W=4 and NUM_VEC=16;
  - MISR polynomial and seed constants;
  - a function returning the expected ZN for a 4-bit vector.
- One sub-module, aoi22_bist_misr (shift/seed/enable), instantiated only under AOI22_BIST_MISR_EN.

## Test plan
- Good-cell model on ZN, defaults, start pulse → done after edge k+48; pass=1; err_cnt=0; first_fail_valid=0; 16 distinct single-bit-step vectors observed.
- ZN stuck at 1 → err_cnt=7, pass=0, first_fail_vec=4'b0011.
- ZN stuck at 0 → err_cnt=9, first_fail_vec=4'b0000.
- PASSES=3, ERR_CNT_W=4, ZN stuck at 0 (27 mismatches) → err_cnt saturates at 15; done after edge k+144.
- abort asserted 10 cycles after start → DONE next edge, pass=0, done pulse once. A start during busy is ignored.
- RN asserted mid-run → all outputs at reset values, no done. With the macro defined, good-cell signature equals the value from the package reference function, and stuck-at-1 produces a different signature.
